// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit width, digit maximum, countdown FSM states and nibble saturation.
package bcd_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPause,
    StDone
  } state_e;

  function automatic logic [BCD_W-1:0] bcd_sat(input logic [BCD_W-1:0] nib);
    return (nib > BCD_MAX) ? BCD_MAX : nib;
  endfunction

endpackage

// File: rtl/bcd_countdown_if.sv
// Control/status bundle of the BCD countdown timer (optional auto-reload: BCD_COUNTDOWN_AUTO_RELOAD_EN).
interface bcd_countdown_if #(
  parameter int unsigned DIGITS = 4
) ();
  import bcd_pkg::*;

  logic                    clr;
  logic                    load;
  logic [BCD_W*DIGITS-1:0] load_val;
  logic                    start;
  logic                    pause;
  logic [BCD_W*DIGITS-1:0] data;
  logic                    running;
  logic                    zero;
  logic                    done;

  modport master (
    output clr, load, load_val, start, pause,
    input  data, running, zero, done
  );

  modport slave (
    input  clr, load, load_val, start, pause,
    output data, running, zero, done
  );

endinterface

// File: rtl/bcd_down_digit.sv
// One BCD digit of the down-counter; steps on en when all lower digits are zero.
module bcd_down_digit
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [BCD_W-1:0] load_nib,
  input  logic             en,
  input  logic             borrow_in,
  output logic [BCD_W-1:0] data,
  output logic             borrow_out
);

  logic [BCD_W-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (clr) begin
      data_d = '0;
    end else if (load) begin
      data_d = bcd_sat(load_nib);
    end else if (en && borrow_in) begin
      data_d = (data_q == '0) ? BCD_MAX : data_q - BCD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data       = data_q;
  assign borrow_out = borrow_in & (data_q == '0);

endmodule

// File: rtl/bcd_countdown.sv
// Multi-digit BCD countdown timer with prescaler and expiry pulse.
// Define BCD_COUNTDOWN_AUTO_RELOAD_EN to reload the preset on expiry and keep running.
module bcd_countdown
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned TICK_DIV = 50000000
) (
  input logic            clk,
  input logic            rst_n,
  bcd_countdown_if.slave bus
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned DW = BCD_W * DIGITS;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DATA_ONE  = DW'(1);

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          done_q, done_d;

  logic [DW-1:0]     data;
  logic [DW-1:0]     load_sat;
  logic [DW-1:0]     load_src;
  logic [DIGITS:0]   borrow;
  logic              tick;
  logic              expire;
  logic              reload_evt;
  logic              digit_load;

  always_comb begin
    load_sat = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      load_sat[i*BCD_W +: BCD_W] = bcd_sat(bus.load_val[i*BCD_W +: BCD_W]);
    end
  end

  // clr/load on the tick cycle suppress the decrement and the expiry
  assign tick   = (state_q == StRun) && (presc_q == PRESC_MAX) && !bus.clr && !bus.load;
  assign expire = tick && (data == DATA_ONE);

`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
  logic [DW-1:0] reload_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reload_q <= '0;
    end else if (bus.load && !bus.clr) begin
      reload_q <= load_sat;
    end
  end

  assign reload_evt = expire && (reload_q != '0);
  assign load_src   = bus.load ? load_sat : reload_q;
`else
  assign reload_evt = 1'b0;
  assign load_src   = load_sat;
`endif

  assign digit_load = bus.load | reload_evt;
  assign borrow[0]  = 1'b1;

  for (genvar i = 0; i < int'(DIGITS); i++) begin : g_digit
    bcd_down_digit u_digit (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (bus.clr),
      .load       (digit_load),
      .load_nib   (load_src[i*BCD_W +: BCD_W]),
      .en         (tick),
      .borrow_in  (borrow[i]),
      .data       (data[i*BCD_W +: BCD_W]),
      .borrow_out (borrow[i+1])
    );
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    done_d  = 1'b0;
    if (bus.clr || bus.load) begin
      state_d = StIdle;
      presc_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          // top of the borrow chain is high only when every digit is zero
          if (bus.start && !borrow[DIGITS]) state_d = StRun;
        end
        StRun: begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (expire) begin
            done_d  = 1'b1;
            state_d = reload_evt ? StRun : StDone;
          end else if (bus.pause && !bus.start) begin
            state_d = StPause;
          end
        end
        StPause: begin
          if (bus.start) state_d = StRun;
        end
        StDone:  state_d = StDone;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      presc_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      done_q  <= done_d;
    end
  end

  assign bus.data    = data;
  assign bus.zero    = borrow[DIGITS];
  assign bus.running = (state_q == StRun);
  assign bus.done    = done_q;

endmodule

// File: doc/bcd_countdown.md
Name: bcd_countdown

Overview:
- Multi-digit BCD down-counter/timer. It is the borrow-chain counterpart of the team's mod-10 up-counters with carry-out.
- Loads a preset, counts down one unit per prescaled tick, and flags expiry.
- Used by the key/display subsystem for countdown functions. It drives the 7-segment digit mux directly from `data`.

Parameters:
- DIGITS, 4, number of cascaded BCD digits (1..8).
- TICK_DIV, 50000000, clk cycles per count step (>=2); 1 Hz at 50 MHz.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- clr  input  1  synchronous clear to zero/IDLE, one-cycle pulse.
- load  input  1  load `load_val`, one-cycle pulse.
- load_val  input  4*DIGITS  BCD preset; digit 0 = bits [3:0].
- start  input  1  start/resume pulse.
- pause  input  1  pause pulse.
- data  output  4*DIGITS  current BCD count value.
- running  output  1  high in RUN.
- zero  output  1  high when all digits are 0.
- done  output  1  one-cycle expiry pulse.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - data=0, state=IDLE, prescaler=0, running=0, done=0.
  - zero=1, because it is combinational from `data`.
- Input priority per cycle: rst_n > clr > load > start > pause.
- clr: data=0, prescaler=0, state=IDLE, done=0. It is valid in any state.
- load:
  - data <= load_val, with any nibble >9 saturated to 9.
  - prescaler=0, state=IDLE; also captures the reload register.
  - load during RUN aborts the run.
- FSM states: IDLE, RUN, PAUSE, DONE.
  - IDLE --start & !zero--> RUN. start while zero is ignored; state stays IDLE.
  - RUN --pause--> PAUSE. Prescaler is held, not cleared.
  - PAUSE --start--> RUN. Counting resumes from the held prescaler value.
  - RUN --tick with data==1--> DONE.
  - DONE --start--> ignored. Leave DONE only via load or clr.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN.
  - tick=1 in the cycle prescaler==TICK_DIV-1; the prescaler then wraps to 0.
  - The first decrement occurs TICK_DIV cycles after the start pulse is sampled.
- Decrement on tick:
  - Digit 0 always steps.
  - Digit k steps when tick and digits 0..k-1 are all 0 (borrow chain).
  - A stepping digit at 0 wraps to 9; otherwise it goes to value-1.
  - Example: 0x0100 -> 0x0099. This is purely synchronous; no ripple clocking.
- Expiry:
  - When a tick takes data from 1 to 0, the next cycle shows data=0, state=DONE, done=1 for exactly one cycle, running=0.
  - data never underflows below 0.
- Simultaneous events:
  - start and pause in the same cycle: start wins.
  - pause in IDLE or DONE: ignored.
  - clr or load on the tick cycle: clr/load wins; no decrement and no done.
- running = (state==RUN). done is registered.

Optional Feature:
- Macro: BCD_COUNTDOWN_AUTO_RELOAD_EN.
- When defined, on expiry the block reloads `data` from the reload register and stays in RUN.
  - done still pulses for one cycle.
  - The prescaler continues from 0 and the zero value is not shown.
  - If the reload register holds 0, the block goes to DONE as in the base behaviour.
- When undefined: no reload register is built, and the base behaviour applies.

Decomposition:
- Shared package bcd_pkg holds:
  - BCD_W=4, BCD_MAX=4'd9.
  - State typedef/encoding (IDLE, RUN, PAUSE, DONE).
  - Function bcd_sat(nibble) for saturating a nibble >9 to 9.
- One natural sub-module, bcd_down_digit:
  - Ports: clk, rst_n, clr, load, load_nib, en (tick), borrow_in, data[3:0], borrow_out.
  - borrow_out = borrow_in & (data==0).
  - Instantiated DIGITS times via generate; borrow_in of digit 0 is tied high.

Test Plan (DIGITS=2, TICK_DIV=4):
- Reset: drop rst_n for 2 cycles, then release -> data=0x00, zero=1, running=0, done=0.
- Load 0x03, start -> data goes 03, 02, 01, 00 at 4-cycle spacing; done high for 1 cycle at 00; state DONE; running=0.
- Load 0x10, start, 1 tick -> data=0x09 (borrow wraps digit 0 to 9, digit 1 to 0). Also load 0xA5 -> data=0x95 (saturation).
- Load 0x05, start, pause after 2 cycles, hold paused 20 cycles -> data stays 05. Then start -> first decrement 2 cycles later, to 04.
- Start with data=0 -> no RUN, running stays 0. Load asserted on the tick cycle -> new value taken, no decrement. clr during RUN -> data=00, IDLE, no done.
- With BCD_COUNTDOWN_AUTO_RELOAD_EN: load 0x02, start -> 02, 01, 02, 01 ..., with a done pulse each expiry. Without the macro -> stops at 00 in DONE.
